// File: rtl/ysyx_22040127_fetch.sv
// Instruction-fetch stage: registered request/response fetch from instruction memory,
// PC redirect handling (branch from ID, mret from WB) and valid/allowin handoff to decode.
module ysyx_22040127_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h80000000,
  parameter int          IF_TO_ID_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_allowin,
  output logic                      if_to_id_valid,
  output logic [IF_TO_ID_WIDTH-1:0] if_to_id_bus,
  input  logic                      br_taken,
  input  logic [31:0]               br_target,
  input  logic                      wb_mret,
  input  logic [31:0]               mepc,
  output logic                      imem_req_valid,
  input  logic                      imem_req_ready,
  output logic [63:0]               imem_req_addr,
  input  logic                      imem_resp_valid,
  input  logic [63:0]               imem_resp_data,
  output logic [31:0]               if_pc,
  output logic                      if_ebreak
);

  localparam logic [31:0] EBREAK_INST = 32'h00100073;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] fetch_pc_reg, fetch_pc_next;
  logic        drop_reg, drop_next;
  logic [31:0] hold_inst_reg, hold_inst_next;
  logic [31:0] hold_pc_reg, hold_pc_next;

  logic        redirect;
  logic [31:0] redirect_target;
  logic        req_accept;
  logic        in_hold;

  assign redirect        = br_taken | wb_mret;
  assign redirect_target = wb_mret ? mepc : br_target;
  assign req_accept      = imem_req_valid & imem_req_ready;
  assign in_hold         = (state_reg == ST_HOLD);

  always_comb begin
    state_next     = state_reg;
    fetch_pc_next  = fetch_pc_reg;
    drop_next      = drop_reg;
    hold_inst_next = hold_inst_reg;
    hold_pc_next   = hold_pc_reg;
    case (state_reg)
      ST_REQ: begin
        if (redirect) begin
          fetch_pc_next = redirect_target;
        end
        if (req_accept) begin
          state_next = ST_WAIT;
          // The request just issued belongs to the old path.
          if (redirect) begin
            drop_next = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (imem_resp_valid) begin
          drop_next  = 1'b0;
          state_next = ST_REQ;
          if (redirect) begin
            fetch_pc_next = redirect_target;
          end else if (!drop_reg) begin
            hold_inst_next = fetch_pc_reg[2] ? imem_resp_data[63:32] : imem_resp_data[31:0];
            hold_pc_next   = fetch_pc_reg;
            state_next     = ST_HOLD;
          end
        end else if (redirect) begin
          fetch_pc_next = redirect_target;
          drop_next     = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          fetch_pc_next = redirect_target;
          state_next    = ST_REQ;
        end else if (id_allowin) begin
          fetch_pc_next = fetch_pc_reg + 32'd4;
          state_next    = ST_REQ;
        end
      end
      default: begin
        state_next = ST_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_REQ;
      fetch_pc_reg  <= RESET_PC;
      drop_reg      <= 1'b0;
      hold_inst_reg <= 32'd0;
      hold_pc_reg   <= 32'd0;
    end else begin
      state_reg     <= state_next;
      fetch_pc_reg  <= fetch_pc_next;
      drop_reg      <= drop_next;
      hold_inst_reg <= hold_inst_next;
      hold_pc_reg   <= hold_pc_next;
    end
  end

  // A redirect in the same cycle kills the held instruction before decode sees it.
  assign if_to_id_valid = in_hold & ~redirect;
  assign if_to_id_bus   = in_hold ? {hold_inst_reg, hold_pc_reg} : '0;
  assign if_ebreak      = if_to_id_valid & (hold_inst_reg == EBREAK_INST);
  assign imem_req_valid = (state_reg == ST_REQ);
  assign imem_req_addr  = {32'd0, fetch_pc_reg[31:3], 3'b000};
  assign if_pc          = fetch_pc_reg;

endmodule

// File: tb/tb_ysyx_22040127_fetch.sv
// Bench for ysyx_22040127_fetch: directed scenarios followed by randomized traffic,
// checked against an instruction-stream model (expected PC sequence plus a memory image).
module tb_ysyx_22040127_fetch;

  localparam logic [31:0] RESET_PC = 32'h80000000;
  localparam logic [31:0] EBREAK   = 32'h00100073;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_allowin = 1'b1;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'd0;
  logic        wb_mret = 1'b0;
  logic [31:0] mepc = 32'd0;
  logic        imem_req_ready = 1'b1;
  logic        imem_resp_valid = 1'b0;
  logic [63:0] imem_resp_data = 64'd0;

  logic        if_to_id_valid;
  logic [63:0] if_to_id_bus;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic [31:0] if_pc;
  logic        if_ebreak;

  ysyx_22040127_fetch #(.RESET_PC(RESET_PC), .IF_TO_ID_WIDTH(64)) dut (
    .clk(clk), .rst(rst), .id_allowin(id_allowin),
    .if_to_id_valid(if_to_id_valid), .if_to_id_bus(if_to_id_bus),
    .br_taken(br_taken), .br_target(br_target), .wb_mret(wb_mret), .mepc(mepc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .if_pc(if_pc), .if_ebreak(if_ebreak)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          deliveries = 0;
  logic [31:0] model_pc = RESET_PC;
  bit          rnd = 1'b0;
  int          fixed_delay = 0;
  bit          mem_busy = 1'b0;
  int          mem_delay = 0;
  logic [63:0] mem_addr = 64'd0;
  logic [63:0] held_bus;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory image: a few fixed words, a scrambled address hash elsewhere.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] b;
    b = {a[31:2], 2'b00};
    case (b)
      32'h80000000: word_at = 32'h00100093;
      32'h80000004: word_at = 32'h00000013;
      32'h80000300: word_at = EBREAK;
      default:      word_at = (b * 32'h9E3779B1) ^ 32'h12345677;
    endcase
  endfunction

  function automatic logic [63:0] dword_at(input logic [63:0] a);
    logic [31:0] base;
    base = {a[31:3], 3'b000};
    dword_at = {word_at(base + 32'd4), word_at(base)};
  endfunction

  function automatic logic [31:0] rand_target();
    case ($urandom_range(0, 5))
      0:       rand_target = 32'h80000300;
      1:       rand_target = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
      default: rand_target = 32'h80000000 + 32'($urandom_range(0, 1023));
    endcase
  endfunction

  // Check this cycle against the model, update the model, then advance to the next cycle.
  task automatic step();
    logic [31:0] exp_inst;
    #1;
    if (rst) begin
      model_pc = RESET_PC;
    end else begin
      exp_inst = word_at(model_pc);
      check_eq("if_pc", if_pc, model_pc);
      if (imem_req_valid)
        check_eq("req_addr", imem_req_addr, {32'd0, model_pc[31:3], 3'b000});
      if (br_taken || wb_mret)
        check_eq("valid_on_redirect", if_to_id_valid, 1'b0);
      if (if_to_id_valid)
        check_eq("bus", if_to_id_bus, {exp_inst, model_pc});
      check_eq("ebreak", if_ebreak, if_to_id_valid && (exp_inst == EBREAK));
      if (imem_req_valid && imem_req_ready) begin
        mem_busy  = 1'b1;
        mem_addr  = imem_req_addr;
        mem_delay = rnd ? $urandom_range(0, 2) : fixed_delay;
      end
      if (wb_mret)
        model_pc = mepc;
      else if (br_taken)
        model_pc = br_target;
      else if (if_to_id_valid && id_allowin) begin
        model_pc = model_pc + 32'd4;
        deliveries++;
      end
    end
    @(negedge clk);
    if (mem_busy && mem_delay == 0) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = dword_at(mem_addr);
      mem_busy        = 1'b0;
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = {$urandom, $urandom};
      if (mem_busy) mem_delay--;
    end
    if (rnd) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      id_allowin     = ($urandom_range(0, 3) != 0);
      br_taken       = ($urandom_range(0, 11) == 0);
      wb_mret        = ($urandom_range(0, 24) == 0);
      br_target      = rand_target();
      mepc           = rand_target();
    end
  endtask

  initial begin
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    // Reset state and first request
    #1;
    check_eq("rst_req_valid", imem_req_valid, 1'b1);
    check_eq("rst_req_addr", imem_req_addr, 64'h80000000);
    check_eq("rst_valid", if_to_id_valid, 1'b0);
    check_eq("rst_bus", if_to_id_bus, 64'd0);
    step();                       // accept
    step();                       // WAIT with response
    #1;
    check_eq("first_valid", if_to_id_valid, 1'b1);
    check_eq("first_bus", if_to_id_bus, {32'h00100093, 32'h80000000});
    step();                       // delivered
    #1;
    check_eq("second_pc", if_pc, 32'h80000004);
    check_eq("second_addr", imem_req_addr, 64'h80000000);
    step();
    step();
    #1;
    check_eq("second_bus", if_to_id_bus, {32'h00000013, 32'h80000004});
    // Stall in HOLD
    id_allowin = 1'b0;
    held_bus = if_to_id_bus;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("stall_valid", if_to_id_valid, 1'b1);
      check_eq("stall_bus", if_to_id_bus, held_bus);
      check_eq("stall_pc", if_pc, 32'h80000004);
      step();
    end
    id_allowin = 1'b1;
    step();
    #1;
    check_eq("advance_once", if_pc, 32'h80000008);
    // Branch while waiting for a response
    fixed_delay = 1;
    step();                       // accept, response one cycle late
    br_taken = 1'b1;
    br_target = 32'h80000100;
    step();                       // WAIT, no response yet
    br_taken = 1'b0;
    #1;
    check_eq("drop_valid", if_to_id_valid, 1'b0);
    step();                       // stale response dropped
    #1;
    check_eq("br_addr", imem_req_addr, 64'h80000100);
    fixed_delay = 0;
    step();
    step();
    #1;
    check_eq("br_bus", if_to_id_bus, {word_at(32'h80000100), 32'h80000100});
    // mret and branch together in HOLD
    wb_mret = 1'b1; mepc = 32'h80000200;
    br_taken = 1'b1; br_target = 32'h80000100;
    step();
    wb_mret = 1'b0; br_taken = 1'b0;
    #1;
    check_eq("mret_pc", if_pc, 32'h80000200);
    step();
    step();
    #1;
    check_eq("mret_bus", if_to_id_bus, {word_at(32'h80000200), 32'h80000200});
    br_taken = 1'b1; br_target = 32'h80000300;
    step();
    br_taken = 1'b0;
    step();
    step();
    #1;
    check_eq("ebreak_set", if_ebreak, 1'b1);
    br_taken = 1'b1; br_target = 32'h80000304;
    #1;
    check_eq("ebreak_kill_valid", if_to_id_valid, 1'b0);
    check_eq("ebreak_kill", if_ebreak, 1'b0);
    step();
    br_taken = 1'b0;
    // Reset during WAIT, stale response right after
    fixed_delay = 1;
    step();                       // accept at 0x80000304
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check_eq("stale_resp_seen", imem_resp_valid, 1'b1);
    check_eq("stale_valid", if_to_id_valid, 1'b0);
    check_eq("stale_addr", imem_req_addr, 64'h80000000);
    fixed_delay = 0;
    step();
    #1;
    check_eq("stale_valid2", if_to_id_valid, 1'b0);
    step();
    #1;
    check_eq("reissue_bus", if_to_id_bus, {32'h00100093, 32'h80000000});
    // Randomized traffic
    deliveries = 0;
    rnd = 1'b1;
    for (int i = 0; i < 4000; i++) step();
    check_eq("progress", deliveries >= 100, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22040127_fetch.md
Name: ysyx_22040127_fetch

Overview:
- Instruction-fetch stage. It replaces the combinational fetch read with a registered request/response handshake to instruction memory.
- It keeps the fetch PC and applies redirects: taken branch from ID, mret from WB.
- It discards wrong-path and in-flight responses.
- It delivers {instruction, pc} to decode over the valid/allowin pipeline handshake.
- It sits directly upstream of ysyx_22040127_decode.

Parameters:
- RESET_PC, 32'h80000000, fetch PC loaded on reset.
- IF_TO_ID_WIDTH, 64, width of if_to_id_bus, laid out as {inst[31:0], pc[31:0]}.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- id_allowin  in  1  decode can accept this cycle.
- if_to_id_valid  out  1  if_to_id_bus holds a valid right-path instruction.
- if_to_id_bus  out  64  {inst, pc}.
- br_taken  in  1  ID redirect request.
- br_target  in  32  ID redirect PC.
- wb_mret  in  1  WB mret redirect request.
- mepc  in  32  mret target.
- imem_req_valid  out  1  fetch request.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  64  {32'b0, fetch_pc[31:3], 3'b000}.
- imem_resp_valid  in  1  response data valid.
- imem_resp_data  in  64  aligned doubleword.
- if_pc  out  32  current fetch PC.
- if_ebreak  out  1  the held instruction equals 32'h00100073 and if_to_id_valid is 1.

Behaviour:
- States: REQ, WAIT, HOLD. Registers: fetch_pc, drop, hold_inst, hold_pc.
- Reset values: state=REQ, fetch_pc=RESET_PC, drop=0, outputs valid=0, bus=0, if_ebreak=0.
- imem_req_valid is high only in REQ. Requests are accepted on req_valid & req_ready. At most one request is outstanding.
- REQ:
  - on accept, go to WAIT.
  - otherwise stay in REQ; imem_req_addr is held stable.
- WAIT:
  - imem_resp_valid is ignored in every other state.
  - On resp_valid with drop=1: clear drop, go to REQ.
  - On resp_valid with drop=0: latch hold_inst = pc[2] ? data[63:32] : data[31:0], latch hold_pc = fetch_pc, go to HOLD.
- HOLD:
  - if_to_id_valid = ~br_taken & ~wb_mret, combinational from the registered hold state.
  - On valid & id_allowin: fetch_pc <= fetch_pc + 4 (32-bit wrap), go to REQ.
  - Otherwise hold all outputs stable.
- Redirect: wb_mret takes priority over br_taken. Target T = wb_mret ? mepc : br_target. It is applied in any state, the same cycle, and the fetch_pc update takes effect next cycle.
  - REQ without accept: fetch_pc <= T, stay in REQ.
  - REQ with accept the same cycle: fetch_pc <= T, drop <= 1, go to WAIT.
  - WAIT, response not arriving: fetch_pc <= T, drop <= 1, stay in WAIT.
  - WAIT, response arriving the same cycle: discard the response, fetch_pc <= T, go to REQ.
  - HOLD: held instruction is discarded and never presented as valid; fetch_pc <= T, go to REQ.
- Back-to-back redirects while drop=1: update fetch_pc only. drop stays 1, so exactly one response is dropped.
- pc[1:0] are ignored; no misalignment fault is raised.
- Throughput: 3 cycles per instruction minimum with zero-wait memory (REQ, WAIT, HOLD).
- if_to_id_bus is driven with the hold registers whenever in HOLD, and is 0 otherwise.
- Reset mid-operation: an outstanding response arriving after reset is never consumed, because state is REQ. Memory is required to be reset with the core.

Test Plan:
- Reset, memory ready, 1-cycle response: first request addr 0x80000000. Data 0x00000013_00100093 gives bus {0x00100093, 0x80000000}; next request addr 0x80000000 and PC 0x80000004; inst 0x00000013.
- HOLD with id_allowin=0 for 5 cycles: valid stays 1, bus stable, fetch_pc unchanged. Raise id_allowin: PC advances by 4 exactly once.
- br_taken=1 with target 0x80000100 while in WAIT: the pending response is dropped, the next request addr is 0x80000100, and no instruction from the old PC reaches ID.
- wb_mret=1 with mepc 0x80000200 and br_taken=1 with target 0x80000100 in the same cycle: fetch resumes at 0x80000200.
- Held inst 0x00100073 with no redirect: if_ebreak=1. The same held inst with br_taken=1: if_to_id_valid=0 and if_ebreak=0.
- rst asserted during WAIT, then a stale resp_valid arrives in the cycle after reset: it is ignored, the request is reissued at RESET_PC, and if_to_id_valid stays 0.
